// File: rtl/bcd_conv_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3 / double dabble).
// Accepts an unsigned or two's-complement operand, converts its magnitude
// one bit per cycle and presents BCD digits, sign, overflow and the count of
// significant digits behind a valid/ready handshake.
module bcd_conv_seq #(
    parameter int DATA_W = 20,
    parameter int DIGITS = 6
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic [DATA_W-1:0]            data_i,
    input  logic                         signed_i,
    input  logic                         valid_i,
    output logic                         ready_o,
    output logic [4*DIGITS-1:0]          bcd_o,
    output logic                         neg_o,
    output logic                         ovf_o,
    output logic [$clog2(DIGITS+1)-1:0]  ndig_o,
    output logic                         valid_o,
    input  logic                         ready_i
);

    localparam int BCD_W  = 4 * DIGITS;
    localparam int CNT_W  = $clog2(DATA_W + 1);
    localparam int NDIG_W = $clog2(DIGITS + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t              state;
    state_t              state_next;

    logic [DATA_W-1:0]   mag;          // magnitude, shifted out MSB first
    logic [BCD_W-1:0]    digits;       // BCD accumulator
    logic [CNT_W-1:0]    cnt;          // remaining shift steps
    logic                sign;         // operand was negative
    logic                ovf_flag;     // sticky: a 1 left the top digit

    logic [BCD_W-1:0]    adj;          // digits after the add-3 correction
    logic [BCD_W-1:0]    digits_next;  // digits after this cycle's shift
    logic                carry;        // bit shifted out of the top digit
    logic                ovf_next;
    logic [NDIG_W-1:0]   ndig_next;

    // State register.
    always_ff @(posedge clk_i) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (!rst_n_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; ready_o is a function of state only.
    always_comb begin
        // NOTE: defaults come first so every path assigns every output and no
        // latch is inferred.
        state_next = state;
        ready_o    = 1'b0;
        case (state)
            IDLE: begin
                ready_o = 1'b1;
                if (valid_i) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == CNT_W'(1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (ready_i) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // One add-3 stage per digit, then the one-bit left shift of {digits, mag}.
    always_comb begin
        adj = digits;
        for (int k = 0; k < DIGITS; k++) begin
            if (digits[4*k +: 4] >= 4'd5) begin
                adj[4*k +: 4] = digits[4*k +: 4] + 4'd3;
            end
        end
        digits_next = {adj[BCD_W-2:0], mag[DATA_W-1]};
        carry       = adj[BCD_W-1];
        ovf_next    = ovf_flag | carry;
    end

    // Significant-digit count of the value being committed on the last shift.
    always_comb begin
        ndig_next = NDIG_W'(1);
        for (int k = 0; k < DIGITS; k++) begin
            if (digits_next[4*k +: 4] != 4'd0) begin
                ndig_next = NDIG_W'(k + 1);
            end
        end
        if (ovf_next) begin
            ndig_next = NDIG_W'(DIGITS);
        end
    end

    // Datapath: operand capture, shift steps and result registers.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            // NOTE: the datapath is a handful of flops, not a memory, and its
            // reset values are visible on the outputs, so it is reset as well.
            mag      <= '0;
            digits   <= '0;
            cnt      <= '0;
            sign     <= 1'b0;
            ovf_flag <= 1'b0;
            bcd_o    <= '0;
            neg_o    <= 1'b0;
            ovf_o    <= 1'b0;
            ndig_o   <= NDIG_W'(1);
            valid_o  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_i) begin
                        // Negating in DATA_W bits keeps -2^(DATA_W-1) exact as
                        // an unsigned magnitude.
                        mag      <= (signed_i && data_i[DATA_W-1]) ? -data_i : data_i;
                        sign     <= signed_i & data_i[DATA_W-1];
                        digits   <= '0;
                        cnt      <= CNT_W'(DATA_W);
                        ovf_flag <= 1'b0;
                    end
                end
                SHIFT: begin
                    digits   <= digits_next;
                    mag      <= {mag[DATA_W-2:0], 1'b0};
                    cnt      <= cnt - CNT_W'(1);
                    ovf_flag <= ovf_next;
                    if (cnt == CNT_W'(1)) begin
                        bcd_o   <= digits_next;
                        // A negative operand always has a nonzero magnitude.
                        neg_o   <= sign;
                        ovf_o   <= ovf_next;
                        ndig_o  <= ndig_next;
                        valid_o <= 1'b1;
                    end
                end
                DONE: begin
                    if (ready_i) begin
                        valid_o <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_conv_seq.sv
// Self-checking bench for bcd_conv_seq (DATA_W=20, DIGITS=6).
// Expected results are queued when an operand is sent and compared by a
// monitor when valid_o rises; scenario tasks check handshake and timing.
module tb_bcd_conv_seq;

    typedef struct {
        logic [23:0] bcd;
        logic        neg;
        logic        ovf;
        logic [2:0]  ndig;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [19:0] data;
    logic        sgn;
    logic        valid_in;
    logic        ready_out;
    logic [23:0] bcd;
    logic        neg;
    logic        ovf;
    logic [2:0]  ndig;
    logic        valid_out;
    logic        ready_in;

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t sb[$];
    exp_t cur;
    bit   have_cur   = 0;
    bit   prev_valid = 0;

    bcd_conv_seq #(.DATA_W(20), .DIGITS(6)) dut (
        .clk_i    (clk),
        .rst_n_i  (rst_n),
        .data_i   (data),
        .signed_i (sgn),
        .valid_i  (valid_in),
        .ready_o  (ready_out),
        .bcd_o    (bcd),
        .neg_o    (neg),
        .ovf_o    (ovf),
        .ndig_o   (ndig),
        .valid_o  (valid_out),
        .ready_i  (ready_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic exp_t mk(input logic [23:0] b, input logic n,
                                input logic o, input logic [2:0] d);
        exp_t e;
        e.bcd  = b;
        e.neg  = n;
        e.ovf  = o;
        e.ndig = d;
        return e;
    endfunction

    // Reference conversion by repeated division.
    function automatic exp_t model(input logic [19:0] d, input logic s);
        exp_t        e;
        logic [19:0] m;
        int unsigned v;
        e.neg  = s & d[19];
        m      = e.neg ? (~d + 20'd1) : d;
        v      = m;
        e.bcd  = '0;
        e.ndig = 3'd1;
        for (int k = 0; k < 6; k++) begin
            e.bcd[4*k +: 4] = 4'(v % 10);
            if ((v % 10) != 0) e.ndig = 3'(k + 1);
            v = v / 10;
        end
        e.ovf = (v != 0);
        if (e.ovf) e.ndig = 3'd6;
        return e;
    endfunction

    // Scoreboard monitor: pop on the rising valid, then require stability.
    always @(negedge clk) begin
        if (valid_out === 1'b1) begin
            if (!prev_valid) begin
                n_checks++;
                if (sb.size() == 0) begin
                    $display("FAIL unexpected_result: valid_o with no operand pending, bcd=%h", bcd);
                end else begin
                    cur      = sb.pop_front();
                    have_cur = 1;
                    if ({bcd, neg, ovf, ndig} !== {cur.bcd, cur.neg, cur.ovf, cur.ndig})
                        $display("FAIL result: got bcd=%h neg=%b ovf=%b ndig=%0d, expected bcd=%h neg=%b ovf=%b ndig=%0d",
                                 bcd, neg, ovf, ndig, cur.bcd, cur.neg, cur.ovf, cur.ndig);
                    else
                        n_pass++;
                end
            end else if (have_cur) begin
                n_checks++;
                if ({bcd, neg, ovf, ndig} !== {cur.bcd, cur.neg, cur.ovf, cur.ndig})
                    $display("FAIL result_stable: got bcd=%h neg=%b ovf=%b ndig=%0d, expected bcd=%h neg=%b ovf=%b ndig=%0d",
                             bcd, neg, ovf, ndig, cur.bcd, cur.neg, cur.ovf, cur.ndig);
                else
                    n_pass++;
            end
        end
        prev_valid = (valid_out === 1'b1);
    end

    // Send one operand (caller sits at a negedge), wait for the result, hold
    // it for 'hold' cycles while disturbing the inputs, then release it.
    task automatic convert(input logic [19:0] d, input logic s, input exp_t e, input int hold);
        int edges;
        n_checks++;
        if (ready_out !== 1'b1) $display("FAIL ready_before_send: got %b expected 1", ready_out);
        else n_pass++;
        data     = d;
        sgn      = s;
        valid_in = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        valid_in = 1'b0;
        data     = 20'($urandom);
        n_checks++;
        if (ready_out !== 1'b0) $display("FAIL accepted: ready_o got %b expected 0 after acceptance", ready_out);
        else n_pass++;
        while (valid_out !== 1'b1 && edges < 60) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        n_checks++;
        if (edges != 21) $display("FAIL latency: got %0d edges expected 21", edges);
        else n_pass++;
        for (int i = 0; i < hold; i++) begin
            valid_in = ~valid_in;
            data     = 20'($urandom);
            sgn      = 1'($urandom);
            @(posedge clk);
            @(negedge clk);
            n_checks++;
            if ({ready_out, valid_out} !== 2'b01)
                $display("FAIL hold: got ready_o=%b valid_o=%b expected ready_o=0 valid_o=1", ready_out, valid_out);
            else
                n_pass++;
        end
        valid_in = 1'b0;
        ready_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ready_in = 1'b0;
        n_checks++;
        if ({ready_out, valid_out} !== 2'b10)
            $display("FAIL release: got ready_o=%b valid_o=%b expected ready_o=1 valid_o=0", ready_out, valid_out);
        else
            n_pass++;
    endtask

    task automatic check_reset_values(input string tag);
        n_checks++;
        if ({ready_out, valid_out, bcd, neg, ovf, ndig} !== {1'b1, 1'b0, 24'h0, 1'b0, 1'b0, 3'd1})
            $display("FAIL %s: got ready=%b valid=%b bcd=%h neg=%b ovf=%b ndig=%0d expected ready=1 valid=0 bcd=000000 neg=0 ovf=0 ndig=1",
                     tag, ready_out, valid_out, bcd, neg, ovf, ndig);
        else
            n_pass++;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        valid_in = 1'b1;          // must be ignored while reset is low
        data     = 20'h00123;
        sgn      = 1'b0;
        ready_in = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset_state");
        valid_in = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (ready_out !== 1'b1) $display("FAIL reset_no_accept: ready_o got %b expected 1", ready_out);
        else n_pass++;
    endtask

    task automatic test_basic();
        convert(20'h03039, 1'b0, mk(24'h012345, 1'b0, 1'b0, 3'd5), 0);
    endtask

    task automatic test_overflow();
        convert(20'hFFFFF, 1'b0, mk(24'h048575, 1'b0, 1'b1, 3'd6), 0);
        convert(20'd999999, 1'b0, mk(24'h999999, 1'b0, 1'b0, 3'd6), 0);
    endtask

    task automatic test_signed();
        convert(20'h80000, 1'b1, mk(24'h524288, 1'b1, 1'b0, 3'd6), 0);
        convert(20'hFFFFF, 1'b1, mk(24'h000001, 1'b1, 1'b0, 3'd1), 0);
        convert(20'h00000, 1'b1, mk(24'h000000, 1'b0, 1'b0, 3'd1), 0);
        convert(20'h7FFFF, 1'b1, mk(24'h524287, 1'b0, 1'b0, 3'd6), 0);
    endtask

    task automatic test_random();
        logic [19:0] d;
        logic        s;
        for (int i = 0; i < 5; i++) begin
            d = 20'($urandom);
            s = 1'($urandom);
            convert(d, s, model(d, s), 0);
        end
    endtask

    task automatic test_back_to_back();
        // Second operand is offered on the cycle right after release.
        convert(20'd777, 1'b0, mk(24'h000777, 1'b0, 1'b0, 3'd3), 10);
        convert(20'd100000, 1'b0, mk(24'h100000, 1'b0, 1'b0, 3'd6), 0);
    endtask

    task automatic test_abort();
        bit saw_valid;
        n_checks++;
        if (ready_out !== 1'b1) $display("FAIL abort_ready: got %b expected 1", ready_out);
        else n_pass++;
        data     = 20'h12345;
        sgn      = 1'b0;
        valid_in = 1'b1;          // no expectation queued: this one is abandoned
        @(posedge clk);
        @(negedge clk);
        valid_in = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;             // reset edge is the 7th shift cycle
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_reset_values("abort_reset_state");
        saw_valid = 0;
        for (int i = 0; i < 30; i++) begin
            if (valid_out !== 1'b0) saw_valid = 1;
            @(negedge clk);
        end
        n_checks++;
        if (saw_valid) $display("FAIL abort_no_valid: valid_o got 1 expected 0");
        else n_pass++;
        convert(20'd42, 1'b0, mk(24'h000042, 1'b0, 1'b0, 3'd2), 0);
    endtask

    initial begin
        valid_in = 1'b0;
        ready_in = 1'b0;
        data     = '0;
        sgn      = 1'b0;
        rst_n    = 1'b0;
        test_reset();
        test_basic();
        test_overflow();
        test_signed();
        test_random();
        test_back_to_back();
        test_abort();
        repeat (2) @(negedge clk);
        n_checks++;
        if (sb.size() != 0) $display("FAIL scoreboard_drained: %0d results outstanding, expected 0", sb.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
